// File: rtl/rms_pk_meter.sv
// Windowed RMS / peak meter: squares and peak are accumulated over 2^LOG2N samples,
// then a restoring bit-serial square root publishes RMS and PIC with a one-cycle ok_SQRT.
module rms_pk_meter #(
  parameter int W     = 12,
  parameter int LOG2N = 10
) (
  input  logic         clk,
  input  logic         NRST,
  input  logic         ce,
  input  logic [W-1:0] X,
  input  logic         bip,
  output logic [W-1:0] RMS,
  output logic [W-1:0] PIC,
  output logic         ok_SQRT,
  output logic         busy,
  output logic         Tmes,
  output logic         err
);

  localparam int AW = 2 * W + LOG2N;
  localparam int RW = W + 3;
  localparam int IW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [W-1:0]     HALF     = {1'b1, {(W-1){1'b0}}};
  localparam logic [LOG2N-1:0] CNT_LAST = '1;
  localparam logic [IW-1:0]    IT_LAST  = IW'(W - 1);

  // ---------------- stage 0: magnitude capture ----------------
  logic [W-1:0] mag_d;
  logic [W-1:0] mag_q;
  logic         vld_q;

  always_comb begin
    mag_d = X;
    if (bip) begin
      mag_d = (X >= HALF) ? (X - HALF) : (HALF - X);
    end
  end

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      mag_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= ce;
      if (ce) begin
        mag_q <= mag_d;
      end
    end
  end

  // ---------------- stage 1: accumulate squares and peak ----------------
  logic [2*W-1:0]   sq;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    acc_sum;
  logic [W-1:0]     pk_q;
  logic [W-1:0]     pk_max;
  logic [W-1:0]     pkr_q;
  logic [LOG2N-1:0] cnt_q;
  logic             tmes_q;
  logic             err_q;
  logic             win_end;
  logic             start;
  logic [2*W-1:0]   mean_w;

  assign sq      = {{W{1'b0}}, mag_q} * {{W{1'b0}}, mag_q};
  assign acc_sum = acc_q + {{LOG2N{1'b0}}, sq};
  assign pk_max  = (mag_q > pk_q) ? mag_q : pk_q;
  assign mean_w  = acc_sum[LOG2N +: 2*W];
  assign win_end = vld_q && (cnt_q == CNT_LAST);
  assign start   = win_end && !busy;

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      acc_q  <= '0;
      pk_q   <= '0;
      pkr_q  <= '0;
      cnt_q  <= '0;
      tmes_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (vld_q) begin
      cnt_q <= cnt_q + LOG2N'(1);
      if (win_end) begin
        // The sample completing this window is folded in here; the next one opens a fresh window.
        acc_q  <= '0;
        pk_q   <= '0;
        tmes_q <= ~tmes_q;
        if (busy) begin
          err_q <= 1'b1;
        end else begin
          pkr_q <= pk_max;
        end
      end else begin
        acc_q <= acc_sum;
        pk_q  <= pk_max;
      end
    end
  end

  // ---------------- restoring bit-serial square root ----------------
  logic [1:0]     state_q, state_d;
  logic [2*W-1:0] rad_q, rad_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [W-1:0]   root_q, root_d;
  logic [IW-1:0]  it_q, it_d;
  logic [W-1:0]   rms_q, rms_d;
  logic [W-1:0]   pic_q, pic_d;
  logic           ok_q, ok_d;
  logic [RW-1:0]  rem_sh;
  logic [RW-1:0]  trial;
  logic           ge;

  // The remainder carries three guard bits so the shifted partial remainder never truncates.
  assign rem_sh = {rem_q[RW-3:0], rad_q[2*W-1 -: 2]};
  assign trial  = {1'b0, root_q, 2'b01};
  assign ge     = (rem_sh >= trial);

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    it_d    = it_q;
    rms_d   = rms_q;
    pic_d   = pic_q;
    ok_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rad_d   = mean_w;
          rem_d   = '0;
          root_d  = '0;
          it_d    = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        rem_d  = ge ? (rem_sh - trial) : rem_sh;
        root_d = {root_q[W-2:0], ge};
        rad_d  = {rad_q[2*W-3:0], 2'b00};
        it_d   = it_q + IW'(1);
        if (it_q == IT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rms_d   = root_q;
        pic_d   = pkr_q;
        ok_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      state_q <= S_IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      it_q    <= '0;
      rms_q   <= '0;
      pic_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      it_q    <= it_d;
      rms_q   <= rms_d;
      pic_q   <= pic_d;
      ok_q    <= ok_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign RMS     = rms_q;
  assign PIC     = pic_q;
  assign ok_SQRT = ok_q;
  assign Tmes    = tmes_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rms_pk_meter.sv
// Directed bench for rms_pk_meter: a W=12/LOG2N=4 instance checked through a result
// scoreboard, plus a LOG2N=2 instance that exercises the overrun flag.
module tb_rms_pk_meter;
  localparam int W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nrst, ce, bip;
  logic [W-1:0] x;
  logic [W-1:0] rms, pic;
  logic         ok, busy, tmes, err;

  logic         nrst2, ce2, bip2;
  logic [W-1:0] x2;
  logic [W-1:0] rms2, pic2;
  logic         ok2, busy2, tmes2, err2;

  rms_pk_meter #(.W(W), .LOG2N(4)) dut (
    .clk(clk), .NRST(nrst), .ce(ce), .X(x), .bip(bip),
    .RMS(rms), .PIC(pic), .ok_SQRT(ok), .busy(busy), .Tmes(tmes), .err(err)
  );

  rms_pk_meter #(.W(W), .LOG2N(2)) dut2 (
    .clk(clk), .NRST(nrst2), .ce(ce2), .X(x2), .bip(bip2),
    .RMS(rms2), .PIC(pic2), .ok_SQRT(ok2), .busy(busy2), .Tmes(tmes2), .err(err2)
  );

  typedef struct {
    int e_rms;
    int e_pic;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total    = 0;
  int   cyc      = 0;
  int   last_ce_cyc = 0;
  int   first_ok_cyc = -1;
  int   pulses  = 0;
  int   pulses2 = 0;
  int   win_cnt = 0;
  logic prev_ok = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int isqrt(input longint v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return int'(r);
  endfunction

  // Result monitor: every ok_SQRT pops one expected window result.
  always @(negedge clk) begin
    if (ok) begin
      exp_t e;
      pulses++;
      if (first_ok_cyc < 0) first_ok_cyc = cyc;
      chk("ok_not_consecutive", 64'(prev_ok), 64'd0);
      chk("result_pending", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("result %0d: RMS=%0d (exp %0d) PIC=%0d (exp %0d) cyc=%0d",
                 pulses, rms, e.e_rms, pic, e.e_pic, cyc);
        chk("RMS", 64'(rms), 64'(e.e_rms));
        chk("PIC", 64'(pic), 64'(e.e_pic));
      end
    end
    prev_ok = ok;
  end

  always @(negedge clk) begin
    if (ok2) begin
      pulses2++;
      $display("dut2 result %0d: RMS=%0d PIC=%0d err=%0d", pulses2, rms2, pic2, err2);
    end
  end

  task automatic send(input int xv, input bit b, input int period);
    ce = 1'b1; x = W'(xv); bip = b;
    @(posedge clk); #1;
    last_ce_cyc = cyc;
    ce = 1'b0;
    repeat (period - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send2(input int xv);
    ce2 = 1'b1; x2 = W'(xv); bip2 = 1'b0;
    @(posedge clk); #1;
    ce2 = 1'b0;
  endtask

  task automatic push(input int r, input int p);
    exp_t e;
    e.e_rms = r;
    e.e_pic = p;
    sb_q.push_back(e);
    win_cnt++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, pb, xv, m, pkm;
    bit b;
    longint s;

    nrst = 1'b0; ce = 1'b0; bip = 1'b0; x = '0;
    nrst2 = 1'b0; ce2 = 1'b0; bip2 = 1'b0; x2 = '0;
    wait_cycles(3);
    chk("reset_RMS", 64'(rms), 64'd0);
    chk("reset_PIC", 64'(pic), 64'd0);
    chk("reset_ok", 64'(ok), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_Tmes", 64'(tmes), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    nrst = 1'b1; nrst2 = 1'b1;
    wait_cycles(2);

    // unipolar constant, sparse ce: latency check
    for (int i = 0; i < 16; i++) send(1000, 1'b0, 8);
    e0 = last_ce_cyc;
    push(1000, 1000);
    drain(100);
    chk("latency", 64'(first_ok_cyc - e0), 64'd14);
    chk("Tmes_after_first", 64'(tmes), 64'd1);
    chk("err_after_first", 64'(err), 64'd0);

    // back-to-back windows, ce every cycle
    for (int i = 0; i < 16; i++) send((i % 2) ? 1548 : 2548, 1'b1, 1);
    push(500, 500);
    for (int i = 0; i < 16; i++) send(0, 1'b1, 1);
    push(2048, 2048);
    for (int i = 0; i < 16; i++) send(4095, 1'b0, 1);
    push(4095, 4095);
    send(3, 1'b0, 1);
    for (int i = 0; i < 15; i++) send(0, 1'b0, 1);
    push(0, 3);
    for (int i = 0; i < 16; i++) send(5, 1'b0, 1);
    push(5, 5);

    // mixed-mode random window against the reference model
    s = 0; pkm = 0;
    for (int i = 0; i < 16; i++) begin
      xv = int'($urandom_range(0, 4095));
      b  = 1'($urandom_range(0, 1));
      m  = b ? ((xv >= 2048) ? xv - 2048 : 2048 - xv) : xv;
      s += longint'(m) * longint'(m);
      if (m > pkm) pkm = m;
      send(xv, b, 2);
    end
    push(isqrt(s >> 4), pkm);
    drain(200);
    chk("Tmes_parity", 64'(tmes), 64'(win_cnt % 2));
    chk("err_clean", 64'(err), 64'd0);
    chk("pulse_count", 64'(pulses), 64'(win_cnt));

    // asynchronous reset mid-window
    for (int i = 0; i < 9; i++) send(700, 1'b0, 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_RMS", 64'(rms), 64'd0);
    chk("async_PIC", 64'(pic), 64'd0);
    chk("async_Tmes", 64'(tmes), 64'd0);
    chk("async_ok", 64'(ok), 64'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    wait_cycles(1);
    pb = pulses;
    for (int i = 0; i < 15; i++) send(700, 1'b0, 1);
    wait_cycles(30);
    chk("no_early_ok", 64'(pulses), 64'(pb));
    send(700, 1'b0, 1);
    push(700, 700);
    drain(50);
    chk("post_reset_pulse", 64'(pulses), 64'(pb + 1));

    // overrun on the short-window instance
    for (int i = 0; i < 4; i++) send2(9);
    for (int i = 0; i < 4; i++) send2(3);
    wait_cycles(40);
    chk("ovr_pulses", 64'(pulses2), 64'd1);
    chk("ovr_RMS_kept", 64'(rms2), 64'd9);
    chk("ovr_PIC_kept", 64'(pic2), 64'd9);
    chk("ovr_err", 64'(err2), 64'd1);
    for (int i = 0; i < 4; i++) send2(6);
    wait_cycles(30);
    chk("after_ovr_pulses", 64'(pulses2), 64'd2);
    chk("after_ovr_RMS", 64'(rms2), 64'd6);
    chk("after_ovr_PIC", 64'(pic2), 64'd6);
    chk("err_sticky", 64'(err2), 64'd1);
    chk("dut2_Tmes", 64'(tmes2), 64'd1);
    chk("dut2_idle", 64'(busy2), 64'd0);
    #2;
    nrst2 = 1'b0;
    #1;
    chk("err_cleared", 64'(err2), 64'd0);
    nrst2 = 1'b1;
    wait_cycles(2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
